// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the round datapath: the reduction constant for
// GF(2^8), the MixColumns mode encodings, the engine state type and the
// constant-multiplier helpers used by the column mixer.
// Every multiplier is built from repeated xtime (multiply by x), so each one
// maps to a small XOR network with no general-purpose GF multiplier.
// -----------------------------------------------------------------------------
package aes_pkg;

  // Low byte of x^8 + x^4 + x^3 + x + 1; the x^8 term is implicit in xtime.
  localparam logic [7:0] AES_POLY = 8'h1B;

  // MixColumns operation select. Code 2'b11 is reserved and handled as bypass.
  localparam logic [1:0] MC_FWD = 2'b00;
  localparam logic [1:0] MC_INV = 2'b01;
  localparam logic [1:0] MC_BYP = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mcState_e;

  // Multiply by x (xtime): shift left and fold the carried-out bit back in.
  function automatic logic [7:0] gf_x2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_x3(input logic [7:0] a);
    return gf_x2(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_x9(input logic [7:0] a);
    return gf_x2(gf_x2(gf_x2(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf_xb(input logic [7:0] a);
    return gf_x2(gf_x2(gf_x2(a))) ^ gf_x2(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_xd(input logic [7:0] a);
    return gf_x2(gf_x2(gf_x2(a))) ^ gf_x2(gf_x2(a)) ^ a;
  endfunction

  function automatic logic [7:0] gf_xe(input logic [7:0] a);
    return gf_x2(gf_x2(gf_x2(a))) ^ gf_x2(gf_x2(a)) ^ gf_x2(a);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// -----------------------------------------------------------------------------
// mix_column_word
// Combinational MixColumns / InvMixColumns for one 32-bit state column.
// Ports:
//   iCol  [0:31]  input column; row r is iCol[8r +: 8] (row 0 = leftmost byte)
//   iInv          1 selects the inverse matrix, 0 the forward matrix
//   oCol  [0:31]  mixed column, same byte ordering as iCol
// -----------------------------------------------------------------------------
module mix_column_word
  import aes_pkg::*;
(
  input  logic [0:31] iCol,
  input  logic        iInv,
  output logic [0:31] oCol
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = iCol[0:7];
  assign a1 = iCol[8:15];
  assign a2 = iCol[16:23];
  assign a3 = iCol[24:31];

  // Both matrices are circulant: every output row reuses the same four
  // coefficients rotated one position to the right.
  always_comb begin
    oCol = '0;
    if (iInv) begin
      oCol[0:7]   = gf_xe(a0) ^ gf_xb(a1) ^ gf_xd(a2) ^ gf_x9(a3);
      oCol[8:15]  = gf_x9(a0) ^ gf_xe(a1) ^ gf_xb(a2) ^ gf_xd(a3);
      oCol[16:23] = gf_xd(a0) ^ gf_x9(a1) ^ gf_xe(a2) ^ gf_xb(a3);
      oCol[24:31] = gf_xb(a0) ^ gf_xd(a1) ^ gf_x9(a2) ^ gf_xe(a3);
    end else begin
      oCol[0:7]   = gf_x2(a0) ^ gf_x3(a1) ^ a2        ^ a3;
      oCol[8:15]  = a0        ^ gf_x2(a1) ^ gf_x3(a2) ^ a3;
      oCol[16:23] = a0        ^ a1        ^ gf_x2(a2) ^ gf_x3(a3);
      oCol[24:31] = gf_x3(a0) ^ a1        ^ a2        ^ gf_x2(a3);
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// -----------------------------------------------------------------------------
// mix_columns_seq
// Sequential AES MixColumns engine (forward, inverse, bypass) that processes
// COLS_PER_CYCLE columns per BUSY cycle, trading area against latency.
// Parameters:
//   COLS_PER_CYCLE  1, 2 or 4 columns per cycle (anything else fails to build)
// Ports:
//   iClk            rising-edge clock
//   iRst_n          asynchronous active-low reset
//   iValid/oReady   input handshake; a state is accepted when both are high
//   iMode   [1:0]   00 forward, 01 inverse, 10 bypass, 11 treated as bypass
//   iState  [0:127] input state, byte k = iState[8k +: 8], column c = bytes 4c..4c+3
//   oValid/iReady   output handshake
//   oState  [0:127] result state, same byte ordering as iState
//   oAbort          synchronous flush back to IDLE (input despite its name)
// -----------------------------------------------------------------------------
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         iValid,
  output logic         oReady,
  input  logic [1:0]   iMode,
  input  logic [0:127] iState,
  output logic         oValid,
  input  logic         iReady,
  output logic [0:127] oState,
  input  logic         oAbort
);

  // Guarded divisor keeps elaboration alive long enough to report a bad value.
  localparam int NUM_PASSES = 4 / ((COLS_PER_CYCLE > 0) ? COLS_PER_CYCLE : 1);
  localparam logic [1:0] LAST_PASS = 2'(NUM_PASSES - 1);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gBadParam
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mcState_e     state, nextState;
  logic [1:0]   count;
  logic [1:0]   modeReg;
  logic [0:127] workReg;
  logic [0:127] resultReg;
  logic         accept;
  logic         lastPass;
  logic         invSel;

  logic [1:0]   colIdx [COLS_PER_CYCLE];
  logic [0:31]  colIn  [COLS_PER_CYCLE];
  logic [0:31]  colOut [COLS_PER_CYCLE];

  assign invSel   = (modeReg == MC_INV);
  assign lastPass = (count == LAST_PASS);
  assign oState   = resultReg;

  // Lane g of pass n handles column n*COLS_PER_CYCLE + g; the column is picked
  // out of the work register by a mux on the pass counter.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : gCol
    assign colIdx[g] = 2'(int'(count) * COLS_PER_CYCLE + g);
    assign colIn[g]  = workReg[{colIdx[g], 5'b00000} +: 32];

    mix_column_word uColumn (
      .iCol (colIn[g]),
      .iInv (invSel),
      .oCol (colOut[g])
    );
  end

  // State register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state and handshake decode. Abort overrides both the accept in IDLE
  // and the DONE->IDLE hand-off, so an aborted cycle never captures a state.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    oReady    = (state == IDLE);
    oValid    = (state == DONE);
    if (oAbort) begin
      nextState = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (iValid) begin
            accept = 1'b1;
            unique case (iMode)
              MC_FWD, MC_INV: nextState = BUSY;
              MC_BYP:         nextState = DONE;
              default:        nextState = DONE;
            endcase
          end
        end
        BUSY: begin
          if (lastPass) begin
            nextState = DONE;
          end
        end
        DONE: begin
          if (iReady) begin
            nextState = IDLE;
          end
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // Datapath. The work register is only loaded on accept so upstream may
  // change iState freely while BUSY. Bypass writes the result directly;
  // the result register is deliberately left alone by an abort.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      count     <= '0;
      modeReg   <= MC_FWD;
      workReg   <= '0;
      resultReg <= '0;
    end else if (oAbort) begin
      count <= '0;
    end else if (accept) begin
      workReg <= iState;
      modeReg <= iMode;
      count   <= '0;
      if (iMode != MC_FWD && iMode != MC_INV) begin
        resultReg <= iState;
      end
    end else if (state == BUSY) begin
      for (int i = 0; i < COLS_PER_CYCLE; i++) begin
        resultReg[{colIdx[i], 5'b00000} +: 32] <= colOut[i];
      end
      count <= lastPass ? 2'd0 : count + 2'd1;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// tb_mix_columns_seq
// Directed bench for mix_columns_seq. Three instances (1, 2 and 4 columns per
// cycle) share every input; most scenarios observe the 1-column instance and
// the inverse scenario compares all three.
// -----------------------------------------------------------------------------
module tb_mix_columns_seq;
  import aes_pkg::*;

  logic         iClk   = 1'b0;
  logic         iRst_n = 1'b0;
  logic         iValid = 1'b0;
  logic         iReady = 1'b1;
  logic         oAbort = 1'b0;
  logic [1:0]   iMode  = 2'b00;
  logic [0:127] iState = '0;

  logic         oReady1, oValid1, oReady2, oValid2, oReady4, oValid4;
  logic [0:127] oState1, oState2, oState4;

  int checks = 0;
  int errors = 0;

  localparam logic [0:127] VEC_A     = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [0:127] VEC_A_FWD = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [0:127] FIPS_IN   = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [0:127] FIPS_OUT  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

  always #5 iClk = ~iClk;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .oReady(oReady1), .iMode(iMode),
    .iState(iState), .oValid(oValid1), .iReady(iReady), .oState(oState1), .oAbort(oAbort)
  );
  mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .oReady(oReady2), .iMode(iMode),
    .iState(iState), .oValid(oValid2), .iReady(iReady), .oState(oState2), .oAbort(oAbort)
  );
  mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .iClk(iClk), .iRst_n(iRst_n), .iValid(iValid), .oReady(oReady4), .iMode(iMode),
    .iState(iState), .oValid(oValid4), .iReady(iReady), .oState(oState4), .oAbort(oAbort)
  );

  // Reference multiply: plain shift-and-add in GF(2^8).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic       hi;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y  = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Reference state transform; row r coefficient for input row j is base[(j-r)&3].
  function automatic logic [0:127] modelState(input logic [1:0] mode, input logic [0:127] s);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [0:127] r;
    int           idx;
    if (mode == 2'b10 || mode == 2'b11) return s;
    if (mode == 2'b00) begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end else begin
      base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          idx = (j - row + 4) % 4;
          acc = acc ^ gmul(base[idx], s[8*(4*c+j) +: 8]);
        end
        r[8*(4*c+row) +: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic applyReset();
    iValid = 1'b0;
    oAbort = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    @(posedge iClk);
    #1;
  endtask

  // Presents one state for exactly one accept edge, then scrambles the inputs
  // so any late sampling of iState/iMode shows up as a wrong result.
  task automatic applyStimulus(input logic [1:0] mode, input logic [0:127] st);
    int waitCycles;
    waitCycles = 0;
    while (!oReady1 && waitCycles < 50) begin
      @(posedge iClk); #1;
      waitCycles++;
    end
    checks++;
    if (oReady1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL acceptReady: oReady=%b required 1", oReady1);
    end
    iValid = 1'b1;
    iMode  = mode;
    iState = st;
    @(posedge iClk); #1;
    iValid = 1'b0;
    iMode  = 2'($urandom_range(0, 3));
    iState = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Edges after the accept edge until oValid is seen (0 = already high).
  task automatic waitValid(output int edges);
    edges = 0;
    while (!oValid1 && edges < 20) begin
      @(posedge iClk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    applyReset();
    checks++;
    if (oReady1 !== 1'b1) begin errors++; $display("[TB] FAIL resetReady1: got %b required 1", oReady1); end
    checks++;
    if (oValid1 !== 1'b0) begin errors++; $display("[TB] FAIL resetValid1: got %b required 0", oValid1); end
    checks++;
    if (oState1 !== '0) begin errors++; $display("[TB] FAIL resetState1: got %h required 0", oState1); end
    checks++;
    if (oReady2 !== 1'b1 || oReady4 !== 1'b1) begin
      errors++; $display("[TB] FAIL resetReady24: got %b%b required 11", oReady2, oReady4);
    end
  endtask

  task automatic test_forward();
    int e;
    iReady = 1'b1;
    applyStimulus(MC_FWD, VEC_A);
    waitValid(e);
    checks++;
    if (e !== 4) begin errors++; $display("[TB] FAIL fwdLatency: got %0d required 4", e); end
    checks++;
    if (oState1 !== VEC_A_FWD) begin errors++; $display("[TB] FAIL fwdState: got %h required %h", oState1, VEC_A_FWD); end
    @(posedge iClk); #1;
    checks++;
    if (oValid1 !== 1'b0 || oReady1 !== 1'b1) begin
      errors++; $display("[TB] FAIL fwdRelease: valid=%b ready=%b required 0/1", oValid1, oReady1);
    end
  endtask

  task automatic test_inverse();
    int lat1, lat2, lat4;
    logic [0:127] st1, st2, st4;
    applyReset();
    iReady = 1'b1;
    lat1 = -1; lat2 = -1; lat4 = -1;
    st1 = '0; st2 = '0; st4 = '0;
    applyStimulus(MC_INV, VEC_A_FWD);
    for (int e = 1; e <= 8; e++) begin
      @(posedge iClk); #1;
      if (oValid1 && lat1 < 0) begin lat1 = e; st1 = oState1; end
      if (oValid2 && lat2 < 0) begin lat2 = e; st2 = oState2; end
      if (oValid4 && lat4 < 0) begin lat4 = e; st4 = oState4; end
    end
    checks++;
    if (lat1 !== 4) begin errors++; $display("[TB] FAIL invLatency1: got %0d required 4", lat1); end
    checks++;
    if (lat2 !== 2) begin errors++; $display("[TB] FAIL invLatency2: got %0d required 2", lat2); end
    checks++;
    if (lat4 !== 1) begin errors++; $display("[TB] FAIL invLatency4: got %0d required 1", lat4); end
    checks++;
    if (st1 !== VEC_A) begin errors++; $display("[TB] FAIL invState1: got %h required %h", st1, VEC_A); end
    checks++;
    if (st2 !== VEC_A) begin errors++; $display("[TB] FAIL invState2: got %h required %h", st2, VEC_A); end
    checks++;
    if (st4 !== VEC_A) begin errors++; $display("[TB] FAIL invState4: got %h required %h", st4, VEC_A); end
  endtask

  task automatic test_fips();
    int e;
    iReady = 1'b1;
    applyStimulus(MC_FWD, FIPS_IN);
    waitValid(e);
    checks++;
    if (e !== 4) begin errors++; $display("[TB] FAIL fipsLatency: got %0d required 4", e); end
    checks++;
    if (oState1 !== FIPS_OUT) begin errors++; $display("[TB] FAIL fipsState: got %h required %h", oState1, FIPS_OUT); end
    @(posedge iClk); #1;
  endtask

  // Bypass result is visible in the first cycle after the accept edge.
  task automatic test_bypass();
    int e;
    iReady = 1'b0;
    applyStimulus(MC_BYP, FIPS_IN);
    waitValid(e);
    checks++;
    if (e !== 0) begin errors++; $display("[TB] FAIL bypLatency: extra edges %0d required 0", e); end
    checks++;
    if (oState1 !== FIPS_IN) begin errors++; $display("[TB] FAIL bypState: got %h required %h", oState1, FIPS_IN); end
    for (int k = 0; k < 5; k++) begin
      @(posedge iClk); #1;
      checks++;
      if (oValid1 !== 1'b1 || oReady1 !== 1'b0 || oState1 !== FIPS_IN) begin
        errors++;
        $display("[TB] FAIL bypHold: valid=%b ready=%b state=%h required 1/0/%h", oValid1, oReady1, oState1, FIPS_IN);
      end
    end
    iReady = 1'b1;
    @(posedge iClk); #1;
    checks++;
    if (oValid1 !== 1'b0 || oReady1 !== 1'b1) begin
      errors++; $display("[TB] FAIL bypRelease: valid=%b ready=%b required 0/1", oValid1, oReady1);
    end
    applyStimulus(2'b11, VEC_A);
    waitValid(e);
    checks++;
    if (e !== 0) begin errors++; $display("[TB] FAIL rsvLatency: extra edges %0d required 0", e); end
    checks++;
    if (oState1 !== VEC_A) begin errors++; $display("[TB] FAIL rsvState: got %h required %h", oState1, VEC_A); end
    @(posedge iClk); #1;
  endtask

  task automatic test_abort();
    int e;
    bit sawValid;
    iReady = 1'b1;
    applyStimulus(MC_FWD, VEC_A);
    @(posedge iClk); #1;
    oAbort = 1'b1;
    @(posedge iClk); #1;
    oAbort = 1'b0;
    checks++;
    if (oReady1 !== 1'b1 || oValid1 !== 1'b0) begin
      errors++; $display("[TB] FAIL abortIdle: ready=%b valid=%b required 1/0", oReady1, oValid1);
    end
    sawValid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge iClk); #1;
      if (oValid1) sawValid = 1'b1;
    end
    checks++;
    if (sawValid !== 1'b0) begin errors++; $display("[TB] FAIL abortNoValid: got %b required 0", sawValid); end
    iValid = 1'b1; oAbort = 1'b1; iMode = MC_BYP; iState = VEC_A;
    @(posedge iClk); #1;
    iValid = 1'b0; oAbort = 1'b0;
    checks++;
    if (oValid1 !== 1'b0 || oReady1 !== 1'b1) begin
      errors++; $display("[TB] FAIL abortOverAccept: valid=%b ready=%b required 0/1", oValid1, oReady1);
    end
    applyStimulus(MC_FWD, FIPS_IN);
    waitValid(e);
    checks++;
    if (e !== 4 || oState1 !== FIPS_OUT) begin
      errors++; $display("[TB] FAIL abortRecover: latency %0d state %h required 4 %h", e, oState1, FIPS_OUT);
    end
    @(posedge iClk); #1;
  endtask

  task automatic test_reset_mid();
    iReady = 1'b1;
    applyStimulus(MC_FWD, VEC_A);
    @(posedge iClk); #1;
    #2 iRst_n = 1'b0;
    #1;
    checks++;
    if (oValid1 !== 1'b0 || oState1 !== '0) begin
      errors++; $display("[TB] FAIL rstBusy: valid=%b state=%h required 0/0", oValid1, oState1);
    end
    @(negedge iClk); iRst_n = 1'b1;
    @(posedge iClk); #1;
    checks++;
    if (oReady1 !== 1'b1 || oValid1 !== 1'b0) begin
      errors++; $display("[TB] FAIL rstBusyRelease: ready=%b valid=%b required 1/0", oReady1, oValid1);
    end
    iReady = 1'b0;
    applyStimulus(MC_BYP, FIPS_IN);
    #2 iRst_n = 1'b0;
    #1;
    checks++;
    if (oValid1 !== 1'b0 || oState1 !== '0) begin
      errors++; $display("[TB] FAIL rstDone: valid=%b state=%h required 0/0", oValid1, oState1);
    end
    @(negedge iClk); iRst_n = 1'b1;
    @(posedge iClk); #1;
    checks++;
    if (oReady1 !== 1'b1) begin errors++; $display("[TB] FAIL rstDoneRelease: ready=%b required 1", oReady1); end
    iReady = 1'b1;
  endtask

  task automatic test_throughput();
    int t0, t1, n;
    bit stateOk;
    applyReset();
    iReady = 1'b1;
    iMode = MC_FWD; iState = VEC_A; iValid = 1'b1;
    t0 = -1; t1 = -1; stateOk = 1'b1;
    for (n = 1; n <= 30 && t1 < 0; n++) begin
      @(posedge iClk); #1;
      if (oValid1) begin
        if (oState1 !== VEC_A_FWD) stateOk = 1'b0;
        if (t0 < 0) t0 = n; else t1 = n;
      end
    end
    iValid = 1'b0;
    checks++;
    if (t0 < 0 || t1 < 0 || (t1 - t0) !== 6) begin
      errors++; $display("[TB] FAIL throughput: interval %0d required 6", t1 - t0);
    end
    checks++;
    if (stateOk !== 1'b1) begin errors++; $display("[TB] FAIL throughputState: got bad state required %h", VEC_A_FWD); end
    applyReset();
  endtask

  task automatic test_back_to_back();
    logic [1:0]   mode;
    logic [0:127] st, expected;
    bit           seen, handshake;
    int           n;
    for (int item = 0; item < 16; item++) begin
      mode     = 2'($urandom_range(0, 3));
      st       = {$urandom, $urandom, $urandom, $urandom};
      expected = modelState(mode, st);
      applyStimulus(mode, st);
      seen = 1'b0;
      n    = 0;
      while (n < 40) begin
        iReady    = 1'($urandom_range(0, 1));
        handshake = oValid1 && iReady;
        if (oValid1) begin
          seen = 1'b1;
          checks++;
          if (oState1 !== expected) begin
            errors++; $display("[TB] FAIL b2bState[%0d]: got %h required %h", item, oState1, expected);
          end
        end
        @(posedge iClk); #1;
        n++;
        if (handshake) break;
      end
      if (!seen) begin
        checks++; errors++;
        $display("[TB] FAIL b2bTimeout[%0d]: oValid=%b required 1", item, oValid1);
      end
    end
    iReady = 1'b1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_fips();
    test_bypass();
    test_abort();
    test_reset_mid();
    test_throughput();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
